// File: rtl/input_bit_shifter_pkg.sv
// Shared helpers for the serial-to-parallel input shifter.
// Only elaboration-time arithmetic lives here; no types are exported.
package input_bit_shifter_pkg;

    function automatic int chunk_count(input int od, input int sd);
        return od / sd;
    endfunction

    function automatic bit divides(input int od, input int sd);
        return (sd > 0) && ((od % sd) == 0);
    endfunction

endpackage

// File: rtl/word_hold_reg.sv
// Valid/ready holding register for completed words.
// A word arriving while the slot is full and not draining is dropped.
module word_hold_reg
    import input_bit_shifter_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         sync_rst_n,
    input  logic         clk_en,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] word,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] data,
    output logic         overflow
);

    logic take;

    assign take = ready || !valid;

    always_ff @(posedge clk) begin
        if (!sync_rst_n) begin
            valid    <= 1'b0;
            data     <= '0;
            overflow <= 1'b0;
        end else if (clk_en) begin
            if (clear) begin
                valid    <= 1'b0;
                data     <= '0;
                overflow <= 1'b0;
            end else if (load && take) begin
                valid <= 1'b1;
                data  <= word;
            end else if (load) begin
                overflow <= 1'b1;
            end else if (valid && ready) begin
                // Idle slot reads as zero.
                valid <= 1'b0;
                data  <= '0;
            end
        end
    end

endmodule

// File: rtl/input_bit_shifter.sv
// Assembles SHIFT_DEPTH-bit chunks, LSB first, into OUTPUT_DEPTH-bit
// words and offers them on a valid/ready port without stalling input.
module input_bit_shifter
    import input_bit_shifter_pkg::*;
#(
    parameter  int OUTPUT_DEPTH = 16,
    parameter  int SHIFT_DEPTH  = 1,
    localparam int WORDS        = chunk_count(OUTPUT_DEPTH, SHIFT_DEPTH),
    localparam int CNT_W        = $clog2(WORDS + 1)
) (
    input  logic                    clk,
    input  logic                    sync_rst_n,
    input  logic                    clk_en,
    input  logic                    shift_en_i,
    input  logic [SHIFT_DEPTH-1:0]  data_i,
    input  logic                    clear_en_i,
    input  logic                    out_ready_i,
    output logic                    out_valid_o,
    output logic [OUTPUT_DEPTH-1:0] data_o,
    output logic                    empty_o,
    output logic [CNT_W-1:0]        fill_count_o,
    output logic                    overflow_o
);

    if (!divides(OUTPUT_DEPTH, SHIFT_DEPTH)) begin : g_bad_cfg
        $error("OUTPUT_DEPTH must be a multiple of SHIFT_DEPTH");
    end

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WORDS - 1);

    logic [OUTPUT_DEPTH-1:0] asm_q;
    logic [OUTPUT_DEPTH-1:0] asm_d;
    logic [CNT_W-1:0]        fill_q;
    logic                    at_last;

    if (WORDS == 1) begin : g_one
        assign asm_d = data_i;
    end else begin : g_many
        assign asm_d = {data_i, asm_q[OUTPUT_DEPTH-1:SHIFT_DEPTH]};
    end

    assign at_last = (fill_q == LAST);

    always_ff @(posedge clk) begin
        if (!sync_rst_n) begin
            asm_q  <= '0;
            fill_q <= '0;
        end else if (clk_en) begin
            if (clear_en_i) begin
                asm_q  <= '0;
                fill_q <= '0;
            end else if (shift_en_i) begin
                asm_q  <= asm_d;
                fill_q <= at_last ? '0 : fill_q + CNT_W'(1);
            end
        end
    end

    // asm_d already holds the full word on the completing shift.
    word_hold_reg #(
        .W(OUTPUT_DEPTH)
    ) u_hold (
        .clk       (clk),
        .sync_rst_n(sync_rst_n),
        .clk_en    (clk_en),
        .clear     (clear_en_i),
        .load      (shift_en_i && at_last),
        .word      (asm_d),
        .ready     (out_ready_i),
        .valid     (out_valid_o),
        .data      (data_o),
        .overflow  (overflow_o)
    );

    assign fill_count_o = fill_q;
    assign empty_o      = (fill_q == '0) && !out_valid_o;

endmodule

// File: tb/tb_input_bit_shifter.sv
// Random and directed bench; an 8/2 instance is tracked by a
// positional model every cycle, a 16/1 instance checked directly.
module tb_input_bit_shifter;

    logic       clk = 1'b0;
    logic       rst_n, ce, clr, rdy, sh8, sh16, d16;
    logic [1:0] d8;

    logic        v8, e8, o8, v16, e16, o16;
    logic [7:0]  q8;
    logic [15:0] q16;
    logic [2:0]  f8;
    logic [4:0]  f16;

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_on   = 0;

    always #5 clk = ~clk;

    input_bit_shifter #(.OUTPUT_DEPTH(8), .SHIFT_DEPTH(2)) dut8 (
        .clk(clk), .sync_rst_n(rst_n), .clk_en(ce),
        .shift_en_i(sh8), .data_i(d8), .clear_en_i(clr),
        .out_ready_i(rdy), .out_valid_o(v8), .data_o(q8),
        .empty_o(e8), .fill_count_o(f8), .overflow_o(o8)
    );

    input_bit_shifter #(.OUTPUT_DEPTH(16), .SHIFT_DEPTH(1)) dut16 (
        .clk(clk), .sync_rst_n(rst_n), .clk_en(ce),
        .shift_en_i(sh16), .data_i(d16), .clear_en_i(clr),
        .out_ready_i(rdy), .out_valid_o(v16), .data_o(q16),
        .empty_o(e16), .fill_count_o(f16), .overflow_o(o16)
    );

    // Model: chunk k of a word lands at bit 2*k of the partial value.
    int         m_cnt  = 0;
    logic [7:0] m_part = '0;
    logic [7:0] m_data = '0;
    bit         m_valid = 0;
    bit         m_ovf   = 0;

    always @(posedge clk) begin : model
        logic [7:0] w;
        bit done;
        w = '0;
        done = 0;
        if (!rst_n || (ce && clr)) begin
            m_cnt = 0; m_part = '0; m_data = '0;
            m_valid = 0; m_ovf = 0;
        end else if (ce) begin
            if (sh8) begin
                m_part = m_part | (8'(d8) << (2 * m_cnt));
                m_cnt++;
                if (m_cnt == 4) begin
                    done = 1; w = m_part;
                    m_part = '0; m_cnt = 0;
                end
            end
            if (done) begin
                if (!m_valid || rdy) begin
                    m_valid = 1; m_data = w;
                end else begin
                    m_ovf = 1;
                end
            end else if (m_valid && rdy) begin
                m_valid = 0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h @%0t",
                     name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            chk("valid", 32'(v8), 32'(m_valid));
            chk("data", 32'(q8), 32'(m_valid ? m_data : 8'h00));
            chk("fill", 32'(f8), 32'(m_cnt));
            chk("ovf", 32'(o8), 32'(m_ovf));
            chk("empty", 32'(e8), 32'(m_cnt == 0 && !m_valid));
        end
    end

    task automatic cyc(input bit c, input bit s, input logic [1:0] d,
                       input bit cl, input bit r, input bit rs);
        ce = c; sh8 = s; d8 = d; clr = cl; rdy = r; rst_n = rs;
        @(posedge clk);
        #1;
    endtask

    task automatic word8(input logic [7:0] w, input bit r);
        for (int i = 0; i < 4; i++) begin
            logic [7:0] t;
            t = w >> (2 * i);
            cyc(1, 1, t[1:0], 0, r, 1);
        end
    endtask

    initial begin
        logic [15:0] v;
        rst_n = 0; ce = 0; clr = 0; rdy = 0;
        sh8 = 0; sh16 = 0; d8 = '0; d16 = 0;

        cyc(0, 1, 2'b11, 0, 1, 0);
        mon_on = 1;
        chk("rst_valid", 32'(v8), 32'd0);
        chk("rst_empty", 32'(e8), 32'd1);
        chk("rst_fill", 32'(f8), 32'd0);
        chk("rst16_empty", 32'(e16), 32'd1);

        // 01,10,11,00 -> 8'h39
        cyc(1, 1, 2'b01, 0, 1, 1);
        cyc(1, 1, 2'b10, 0, 1, 1);
        cyc(1, 1, 2'b11, 0, 1, 1);
        chk("w1_notyet", 32'(v8), 32'd0);
        cyc(1, 1, 2'b00, 0, 1, 1);
        chk("w1_valid", 32'(v8), 32'd1);
        chk("w1_data", 32'(q8), 32'h39);
        chk("w1_model", 32'(m_data), 32'h39);
        chk("w1_empty", 32'(e8), 32'd0);
        cyc(1, 0, 2'b00, 0, 1, 1);
        chk("w1_drained", 32'(e8), 32'd1);

        // Overflow: second word dropped, first held
        word8(8'h1B, 0);
        word8(8'hC0, 0);
        chk("ovf_flag", 32'(o8), 32'd1);
        chk("ovf_keep", 32'(q8), 32'h1B);
        cyc(1, 0, 2'b00, 0, 0, 1);
        chk("ovf_sticky", 32'(o8), 32'd1);
        cyc(1, 0, 2'b00, 1, 0, 1);
        chk("clr_ovf", 32'(o8), 32'd0);
        chk("clr_valid", 32'(v8), 32'd0);
        chk("clr_empty", 32'(e8), 32'd1);

        // Replace held word while transferring
        word8(8'h1B, 0);
        cyc(1, 1, 2'b01, 0, 0, 1);
        cyc(1, 1, 2'b01, 0, 0, 1);
        cyc(1, 1, 2'b01, 0, 0, 1);
        cyc(1, 1, 2'b01, 0, 1, 1);
        chk("rep_valid", 32'(v8), 32'd1);
        chk("rep_data", 32'(q8), 32'h55);
        chk("rep_ovf", 32'(o8), 32'd0);
        cyc(1, 0, 2'b00, 0, 1, 1);

        // Reset mid-word leaves no residue
        for (int i = 0; i < 3; i++) cyc(1, 1, 2'b10, 0, 1, 1);
        cyc(1, 0, 2'b00, 0, 1, 0);
        word8(8'hFF, 1);
        chk("rst_mid_data", 32'(q8), 32'hFF);
        cyc(1, 0, 2'b00, 0, 1, 1);

        // clk_en low freezes everything
        word8(8'h1B, 0);
        cyc(1, 1, 2'b10, 0, 0, 1);
        for (int i = 0; i < 5; i++)
            cyc(0, 1'($urandom), 2'($urandom), 0, 1'($urandom), 1);
        chk("ce_fill", 32'(f8), 32'd1);
        chk("ce_valid", 32'(v8), 32'd1);
        chk("ce_data", 32'(q8), 32'h1B);
        cyc(1, 1, 2'b01, 1, 1, 1);
        chk("clr_win_fill", 32'(f8), 32'd0);
        chk("clr_win_valid", 32'(v8), 32'd0);

        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 7,
                2'($urandom), $urandom_range(0, 49) == 0,
                1'($urandom), $urandom_range(0, 99) != 0);

        // 16-bit, 1-bit chunks
        cyc(1, 0, 2'b00, 0, 1, 0);
        v = 16'hA5C3;
        for (int i = 0; i < 16; i++) begin
            sh16 = 1; d16 = v[i];
            cyc(1, 0, 2'b00, 0, 1, 1);
        end
        sh16 = 0;
        chk("w16_valid", 32'(v16), 32'd1);
        chk("w16_data", 32'(q16), 32'hA5C3);
        chk("w16_fill", 32'(f16), 32'd0);
        chk("w16_ovf", 32'(o16), 32'd0);

        mon_on = 0;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/input_bit_shifter.md
INPUT_BIT_SHIFTER -- requirements
Module: input_bit_shifter

Interface
REQ-001 Parameter OUTPUT_DEPTH, default 16: width of the assembled parallel word in bits.
REQ-002 Parameter SHIFT_DEPTH, default 1: bits accepted per shift; OUTPUT_DEPTH SHALL be an integer multiple of SHIFT_DEPTH (elaboration error otherwise).
REQ-003 Derived constants: WORDS = OUTPUT_DEPTH/SHIFT_DEPTH; CNT_W = $clog2(WORDS+1).
REQ-004 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 sync_rst_n  input  1  reset, synchronous, active-low.
REQ-006 clk_en  input  1  clock enable; state SHALL change only when high, except reset.
REQ-007 shift_en_i  input  1  accept data_i this cycle.
REQ-008 data_i  input  SHIFT_DEPTH  serial chunk, first-received chunk is least significant.
REQ-009 clear_en_i  input  1  discard partial word, held word and overflow flag.
REQ-010 out_ready_i  input  1  consumer accepts data_o.
REQ-011 out_valid_o  output  1  data_o holds a complete word.
REQ-012 data_o  output  OUTPUT_DEPTH  assembled word.
REQ-013 empty_o  output  1  no partial chunks and no held word.
REQ-014 fill_count_o  output  CNT_W  chunks in the partial word, 0..WORDS-1.
REQ-015 overflow_o  output  1  sticky; a completed word was dropped.

Function
REQ-016 Shift: on clk_en && shift_en_i, the assembly register SHALL load {data_i, assembly[OUTPUT_DEPTH-1:SHIFT_DEPTH]} and fill_count SHALL increment.
REQ-017 Completion: a shift with fill_count == WORDS-1 completes a word; fill_count SHALL wrap to 0 in that cycle.
REQ-018 A completed word SHALL be written to the holding register, and out_valid_o SHALL be high on the next cycle (latency 1), provided the holding register is free or is being emptied in the same cycle.
REQ-019 Handshake: a transfer occurs on clk_en && out_valid_o && out_ready_i; out_valid_o SHALL then drop next cycle unless a word completes in the same cycle.
REQ-020 Simultaneous completion and transfer: the new word SHALL replace the held word, and out_valid_o SHALL stay high with no gap.
REQ-021 While out_valid_o is high and no transfer occurs, data_o SHALL remain stable.
REQ-022 Overflow: if a word completes while out_valid_o && !out_ready_i, the new word SHALL be dropped, the held word kept, overflow_o set, and fill_count still wrap to 0.
REQ-023 Assembly continues while a word is held; shifting is never stalled, so an upstream source needs no backpressure.
REQ-024 clear_en_i (with clk_en) SHALL take priority over a same-cycle shift or transfer and SHALL zero the assembly register, holding register, fill_count, out_valid_o and overflow_o.
REQ-025 empty_o = (fill_count_o == 0) && !out_valid_o; it is combinational from registers only.
REQ-026 shift_en_i with clk_en low SHALL be ignored; out_ready_i with clk_en low SHALL not count as a transfer.
REQ-027 data_o SHALL read zero whenever out_valid_o is low after reset or clear.

Reset
REQ-028 While sync_rst_n is low at a clock edge, regardless of clk_en: out_valid_o=0, data_o=0, fill_count_o=0, overflow_o=0, empty_o=1, assembly register=0.
REQ-029 Reset asserted mid-word or with a held word SHALL discard both; the first shift after release starts a new word at fill_count 0.

Structure
REQ-030 No new package types; WORDS/CNT_W SHALL be local derived parameters; reuse the existing sys_structs package only if a shared type is needed.
REQ-031 One sub-module is natural: word_hold_reg (valid/ready holding register with overflow detect), instantiated once.
REQ-032 Target size is 120-400 RTL lines, with no latches and all outputs registered except empty_o.

Verification (OUTPUT_DEPTH=8, SHIFT_DEPTH=2 unless stated)
REQ-033 Shift 2'b01,2'b10,2'b11,2'b00 on consecutive cycles, out_ready_i=1 -> out_valid_o=1 one cycle after the 4th shift, data_o=8'h39, fill_count_o=0, empty_o=0 then 1 after transfer.
REQ-034 Two back-to-back words, out_ready_i=0 -> first word held, second dropped, overflow_o=1 sticky, data_o unchanged; clear_en_i -> overflow_o=0, out_valid_o=0, empty_o=1.
REQ-035 Word held, next word completes in the same cycle out_ready_i=1 -> out_valid_o stays 1, data_o updates to the new word, overflow_o=0.
REQ-036 After 3 shifts, assert sync_rst_n=0 for one cycle, then shift 4 chunks of 2'b11 -> data_o=8'hFF; no residue from the pre-reset chunks.
REQ-037 clk_en=0 while toggling shift_en_i/out_ready_i for 5 cycles -> no change in fill_count_o, out_valid_o or data_o; clear and shift in the same cycle -> clear wins, fill_count_o=0.
REQ-038 OUTPUT_DEPTH=16, SHIFT_DEPTH=1, shift 16'hA5C3 LSB-first -> data_o=16'hA5C3.
